// File: rtl/dp_ram_bist.sv
// Dual-port RAM (A read/write, B read-only) with zero-fill init and a nibble-serial debug engine.
// Optional per-word even parity, checked on port B reads, enabled by DP_RAM_PARITY_EN.
module dp_ram_bist #(
  parameter int unsigned ADDR_WIDTH    = 6,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned INIT_ON_RESET = 1,
  parameter logic [7:0]  SRAM_ID       = 8'h00
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_a_en,
  input  logic                  i_a_we,
  input  logic [ADDR_WIDTH-1:0] i_a_addr,
  input  logic [DATA_WIDTH-1:0] i_a_wdata,
  input  logic [DATA_WIDTH-1:0] i_a_wmask,
  output logic [DATA_WIDTH-1:0] o_a_rdata,
  input  logic                  i_b_en,
  input  logic [ADDR_WIDTH-1:0] i_b_addr,
  output logic [DATA_WIDTH-1:0] o_b_rdata,
  output logic                  o_func_ready,
  output logic                  o_init_done,
  output logic                  o_parity_err,
  input  logic [2:0]            i_bist_cmd,
  input  logic [3:0]            i_bist_din,
  output logic [3:0]            o_bist_dout
);

  localparam int unsigned DEPTH   = 2 ** ADDR_WIDTH;
  localparam int unsigned AN      = (ADDR_WIDTH + 3) / 4;
  localparam int unsigned DN      = (DATA_WIDTH + 3) / 4;
  localparam int unsigned TXW     = DN * 4;
  localparam int unsigned CNT_MAX = (AN > DN) ? AN : DN;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0] CMD_ID   = 3'd1;
  localparam logic [2:0] CMD_ADDR = 3'd2;
  localparam logic [2:0] CMD_DATA = 3'd3;
  localparam logic [2:0] CMD_READ = 3'd4;

  typedef enum logic [3:0] {
    StIdle, StId, StAddr, StCmd, StRdIssue, StRdCap, StSend, StRecv, StWrIssue
  } state_e;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  state_e                r_state;
  logic [3:0]            r_id_nib;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_wr;
  logic [DATA_WIDTH-1:0] r_rd;
  logic [TXW-1:0]        r_tx;
  logic                  r_func_ready;
  logic [ADDR_WIDTH:0]   r_init_cnt;
  logic                  r_init_done;
  logic [DATA_WIDTH-1:0] r_a_rdata;
  logic [DATA_WIDTH-1:0] r_b_rdata;

  logic                  w_init_we;
  logic                  w_init_done_nxt;
  logic                  w_dbg_we;
  logic                  w_a_acc;
  logic                  w_a_we;
  logic                  w_b_acc;
  logic [DATA_WIDTH-1:0] w_a_merged;

  assign w_init_we       = ~r_init_done & ~r_init_cnt[ADDR_WIDTH];
  assign w_init_done_nxt = r_init_done | r_init_cnt[ADDR_WIDTH];
  assign w_dbg_we        = (r_state == StWrIssue);
  assign w_a_acc         = i_a_en & r_func_ready;
  assign w_a_we          = w_a_acc & i_a_we;
  assign w_b_acc         = i_b_en & r_func_ready;
  assign w_a_merged      = (r_mem[i_a_addr] & ~i_a_wmask) | (i_a_wdata & i_a_wmask);

  // Init sweeps index 0..DEPTH-1; the counter's top bit marks the sweep as finished.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_init_cnt  <= '0;
      r_init_done <= (INIT_ON_RESET == 0);
    end else if (!r_init_done) begin
      if (r_init_cnt[ADDR_WIDTH]) r_init_done <= 1'b1;
      else                        r_init_cnt  <= r_init_cnt + (ADDR_WIDTH + 1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_init_we)     r_mem[r_init_cnt[ADDR_WIDTH-1:0]] <= '0;
    else if (w_dbg_we) r_mem[r_addr]                     <= r_wr;
    else if (w_a_we)   r_mem[i_a_addr]                   <= w_a_merged;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      if (w_a_acc) r_a_rdata <= r_mem[i_a_addr];
      if (w_b_acc) r_b_rdata <= r_mem[i_b_addr];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_id_nib     <= '0;
      r_addr       <= '0;
      r_cnt        <= '0;
      r_wr         <= '0;
      r_rd         <= '0;
      r_tx         <= '0;
      r_func_ready <= 1'b0;
    end else begin
      r_func_ready <= w_init_done_nxt;
      if (r_init_done) begin
        unique case (r_state)
          StIdle: begin
            if (i_bist_cmd == CMD_ID) begin
              r_id_nib <= i_bist_din;
              r_state  <= StId;
            end
          end
          StId: begin
            if (i_bist_cmd == CMD_ID && {r_id_nib, i_bist_din} == SRAM_ID) begin
              r_state <= StAddr;
              r_cnt   <= '0;
            end else begin
              r_state <= StIdle;
            end
          end
          StAddr: begin
            if (i_bist_cmd == CMD_ADDR) begin
              r_addr <= ADDR_WIDTH'({r_addr, i_bist_din});
              if (r_cnt == CNT_W'(AN - 1)) begin
                r_state <= StCmd;
                r_cnt   <= '0;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end else begin
              r_state <= StIdle;
            end
          end
          StCmd: begin
            case (i_bist_cmd)
              CMD_READ: begin
                r_state      <= StRdIssue;
                r_func_ready <= 1'b0;
              end
              CMD_DATA: begin
                r_wr  <= DATA_WIDTH'(i_bist_din);
                r_cnt <= CNT_W'(1);
                if (DN == 1) begin
                  r_state      <= StWrIssue;
                  r_func_ready <= 1'b0;
                end else begin
                  r_state <= StRecv;
                end
              end
              CMD_ID: begin
                r_id_nib <= i_bist_din;
                r_state  <= StId;
              end
              default: ;
            endcase
          end
          StRdIssue: begin
            r_rd    <= r_mem[r_addr];
            r_state <= StRdCap;
          end
          StRdCap: begin
            r_tx    <= TXW'(r_rd);
            r_cnt   <= '0;
            r_state <= StSend;
          end
          StSend: begin
            if (i_bist_cmd == CMD_DATA) begin
              r_tx <= r_tx << 4;
              if (r_cnt == CNT_W'(DN - 1)) begin
                r_state <= StCmd;
                r_cnt   <= '0;
                r_addr  <= r_addr + ADDR_WIDTH'(1);
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end else begin
              r_state <= StIdle;
            end
          end
          StRecv: begin
            if (i_bist_cmd == CMD_DATA) begin
              r_wr <= DATA_WIDTH'({r_wr, i_bist_din});
              if (r_cnt == CNT_W'(DN - 1)) begin
                r_state      <= StWrIssue;
                r_func_ready <= 1'b0;
                r_cnt        <= '0;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end else begin
              r_state <= StIdle;
            end
          end
          StWrIssue: begin
            r_addr  <= r_addr + ADDR_WIDTH'(1);
            r_state <= StCmd;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

`ifdef DP_RAM_PARITY_EN
  logic r_par [DEPTH];
  logic r_parity_err;
  logic r_dbg_rd_sticky;

  always_ff @(posedge i_clk) begin
    if (w_init_we)     r_par[r_init_cnt[ADDR_WIDTH-1:0]] <= 1'b0;
    else if (w_dbg_we) r_par[r_addr]                     <= ^r_wr;
    else if (w_a_we)   r_par[i_a_addr]                   <= ^w_a_merged;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_parity_err    <= 1'b0;
      r_dbg_rd_sticky <= 1'b0;
    end else begin
      r_parity_err <= w_b_acc & ((^r_mem[i_b_addr]) != r_par[i_b_addr]);
      if (r_state == StRdIssue) r_dbg_rd_sticky <= 1'b1;
    end
  end

  assign o_parity_err = r_parity_err;
`else
  assign o_parity_err = 1'b0;
`endif

  assign o_a_rdata    = r_a_rdata;
  assign o_b_rdata    = r_b_rdata;
  assign o_func_ready = r_func_ready;
  assign o_init_done  = r_init_done;
  // Outgoing nibble is visible in the same cycle the SHIFT_DATA that consumes it is presented.
  assign o_bist_dout  = (r_state == StSend) ? r_tx[TXW-1 -: 4] : 4'h0;

endmodule

// File: doc/dp_ram_bist.md
Name: dp_ram_bist

Overview:
- Parametrised successor to the single-port BIST-wrapped RAM.
- Has one read/write port (A) and one read-only port (B) on a behavioural array.
- A nibble-serial debug engine sizes its shift lengths from DATA_WIDTH and ADDR_WIDTH; it does not use fixed JTAG frames.
- The debug engine supports burst access with address auto-increment.
- Sits under cache/tag arrays; the debug side connects to the RTAP SRAM chain.

Parameters:
- ADDR_WIDTH, 6: array depth is 2^ADDR_WIDTH words. Range 1..16.
- DATA_WIDTH, 32: word width. Range 1..512.
- INIT_ON_RESET, 1: when 1, the array is zero-filled after reset.
- SRAM_ID, 8'h00: instance ID. It is compared against the shifted-in ID.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- a_en  in  1  port A access request.
- a_we  in  1  port A: 1 = write, 0 = read.
- a_addr  in  ADDR_WIDTH  port A address.
- a_wdata  in  DATA_WIDTH  port A write data.
- a_wmask  in  DATA_WIDTH  port A bit-write enable. 1 = write the bit.
- a_rdata  out  DATA_WIDTH  port A read data.
- b_en  in  1  port B read request.
- b_addr  in  ADDR_WIDTH  port B address.
- b_rdata  out  DATA_WIDTH  port B read data.
- func_ready  out  1  functional ports own the array.
- init_done  out  1  zero-fill complete.
- parity_err  out  1  parity error on the port B read. See Optional Feature.
- bist_cmd  in  3  debug command: 0 NOP, 1 SHIFT_ID, 2 SHIFT_ADDR, 3 SHIFT_DATA, 4 READ.
- bist_din  in  4  debug nibble in.
- bist_dout  out  4  debug nibble out.

Behaviour:
- Reset values:
  - a_rdata, b_rdata, bist_dout, parity_err = 0.
  - func_ready = 0.
  - init_done = 0 when INIT_ON_RESET = 1, otherwise 1.
  - FSM state = IDLE; all shift and counter registers = 0.
- Array access:
  - Reads are synchronous with 1-cycle latency. a_rdata/b_rdata update the cycle after en, and hold their value otherwise.
  - Port A write: mem[a_addr] = (mem & ~a_wmask) | (a_wdata & a_wmask).
  - A write and a B read to the same address in the same cycle: B returns the old data (read-first).
  - An A read of the address it is writing returns the old data.
- func_ready:
  - func_ready = init_done and FSM not in RD_ISSUE or WR_ISSUE.
  - a_en/b_en presented while func_ready = 0 are ignored. No rdata update occurs; the requester holds and retries.
- Init (INIT_ON_RESET = 1):
  - Starts the first cycle after rst deasserts.
  - Writes zero to index 0..2^ADDR_WIDTH-1, one per cycle.
  - init_done rises the cycle after the last index is written.
  - Reset asserted mid-init restarts from index 0.
  - bist_cmd is ignored until init_done = 1.
- Derived constants:
  - AN = ceil(ADDR_WIDTH/4) address nibbles.
  - DN = ceil(DATA_WIDTH/4) data nibbles.
  - Shifted values are MSB-first and right-aligned; excess high bits are discarded.
- FSM:
  - IDLE: SHIFT_ID loads nibble 1 -> ID.
  - ID: SHIFT_ID loads nibble 2. If the full byte equals SRAM_ID -> ADDR, otherwise -> IDLE.
  - ADDR: AN SHIFT_ADDR cycles, then -> CMD.
  - CMD:
    - NOP holds.
    - READ -> RD_ISSUE.
    - SHIFT_DATA takes nibble 1 -> RECV. DN = 1 goes directly to WR_ISSUE.
    - SHIFT_ID -> ID.
  - RD_ISSUE: array read at the address register -> RD_CAP.
  - RD_CAP: latch the word into the output shifter -> SEND.
  - SEND: each SHIFT_DATA presents the next MSB nibble on bist_dout that cycle and shifts. After DN nibbles -> CMD.
  - RECV: receives a total of DN nibbles, then -> WR_ISSUE.
  - WR_ISSUE: full-mask write of the shifted word -> CMD.
  - Leaving SEND or WR_ISSUE increments the address register. It wraps from 2^ADDR_WIDTH-1 to 0.
  - Any command other than the one expected in ID, ADDR, SEND or RECV aborts to IDLE with no array write.
  - bist_dout = 0 outside SEND.
- Debug access owns the array only in RD_ISSUE and WR_ISSUE. A functional request in that cycle is dropped.

Optional Feature:
- Macro: DP_RAM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed on the merged write data for both port A and debug writes.
  - Init writes parity 0.
  - parity_err = 1 for one cycle, aligned with b_rdata, when the stored parity mismatches.
  - A debug read sets bit 0 of a hidden sticky flag, cleared by reset; the flag does not change any other behaviour.
- Undefined: no parity storage; parity_err is tied to 0.

Test Plan:
- Reset with ADDR_WIDTH = 6, INIT_ON_RESET = 1 -> init_done rises exactly 65 cycles after rst falls. A port B read of address 0x3F then returns 0.
- Port A write 0xDEADBEEF to address 5 with mask 0xFFFF0000 over zero, plus a same-cycle port B read of address 5 -> b_rdata = 0. A later read returns 0xDEAD0000.
- Debug sequence: ID nibbles 0x0,0x0 (SRAM_ID = 0); ADDR nibbles 0x1,0x0; SHIFT_DATA x8 with 0x1..0x8 -> mem[0x10] = 0x12345678. func_ready is low for exactly the WR_ISSUE cycle; the address register ends at 0x11.
- Burst: from CMD at address 0x3F, READ then 8 SHIFT_DATA -> bist_dout streams the stored word MSB nibble first. The address wraps to 0x00, and a second READ returns mem[0].
- Wrong ID 0x5A vs SRAM_ID 0x00 -> FSM is back in IDLE. A following READ causes no array access; func_ready stays 1.
- With DP_RAM_PARITY_EN: force a flipped stored bit at address 3, then port B read address 3 -> parity_err = 1 for one cycle with b_rdata. An unmodified address gives 0.
